// File: rtl/alu_pkg.sv
// ---------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the sequential ALU: operation codes, the controller
// state type and the default operand width.
// No ports; imported by seq_alu and seq_muldiv.
// ---------------------------------------------------------------------------
package alu_pkg;

   localparam int DEFAULT_WIDTH = 8;

   // Operation codes presented on the 4-bit op input; 13-15 are reserved.
   typedef enum logic [3:0] {
      OP_AND  = 4'd0,
      OP_OR   = 4'd1,
      OP_XOR  = 4'd2,
      OP_XNOR = 4'd3,
      OP_NAND = 4'd4,
      OP_NOR  = 4'd5,
      OP_NOT  = 4'd6,
      OP_SHL  = 4'd7,
      OP_SHR  = 4'd8,
      OP_ADD  = 4'd9,
      OP_SUB  = 4'd10,
      OP_MUL  = 4'd11,
      OP_DIV  = 4'd12
   } op_e;

   // Controller states: idle, or running the iterative engine.
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      MUL  = 2'd1,
      DIV  = 2'd2
   } state_e;

endpackage

// File: rtl/seq_muldiv.sv
// ---------------------------------------------------------------------------
// seq_muldiv
// Iterative unsigned engine: shift-add multiply (mode=0) or restoring
// divide (mode=1), one iteration per clock, WIDTH iterations per operation.
// Ports:
//   clk, rst_n  clock and asynchronous active-low reset
//   load        capture a/b/mode and start a new operation
//   mode        0 = multiply, 1 = divide
//   a, b        operands (multiplier/multiplicand, dividend/divisor)
//   step_done   high during the cycle whose iteration is the last one
//   hi, lo      value after the current iteration: high/low product,
//               or remainder/quotient
// ---------------------------------------------------------------------------
module seq_muldiv
   import alu_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load,
   input  logic             mode,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             step_done,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   localparam int SHW = $clog2(WIDTH);
   localparam logic [SHW-1:0] LAST_STEP = SHW'(WIDTH - 1);

   logic [WIDTH-1:0] acc_hi;
   logic [WIDTH-1:0] acc_lo;
   logic [WIDTH-1:0] operand_b;
   logic             mode_r;
   logic             active;
   logic [SHW-1:0]   count;

   logic [WIDTH:0]   add_sum;
   logic [WIDTH:0]   shifted;
   logic             fits;
   logic [WIDTH-1:0] trial;

   // One iteration of either algorithm. hi/lo expose the post-iteration
   // value so the controller can capture the final result on the same edge
   // that performs the last iteration.
   // Multiply: conditionally add b into the high half, then shift the
   // whole {carry,hi,lo} right by one; after WIDTH steps {hi,lo} = a*b.
   // Divide: shift the next dividend bit into the partial remainder and
   // subtract the divisor when it fits; trial only needs WIDTH bits because
   // a fitting difference is always smaller than the divisor.
   always_comb begin
      add_sum = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, operand_b} : '0);
      shifted = {acc_hi, acc_lo[WIDTH-1]};
      fits    = (shifted >= {1'b0, operand_b});
      trial   = shifted[WIDTH-1:0] - operand_b;
      if (mode_r) begin
         hi = fits ? trial : shifted[WIDTH-1:0];
         lo = {acc_lo[WIDTH-2:0], fits};
      end else begin
         hi = add_sum[WIDTH:1];
         lo = {add_sum[0], acc_lo[WIDTH-1:1]};
      end
      step_done = active && (count == LAST_STEP);
   end

   // Engine state: load primes the accumulators, then each active cycle
   // commits one iteration until the last one has been taken.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc_hi    <= '0;
         acc_lo    <= '0;
         operand_b <= '0;
         mode_r    <= 1'b0;
         active    <= 1'b0;
         count     <= '0;
      end else if (load) begin
         acc_hi    <= '0;
         acc_lo    <= a;
         operand_b <= b;
         mode_r    <= mode;
         active    <= 1'b1;
         count     <= '0;
      end else if (active) begin
         acc_hi <= hi;
         acc_lo <= lo;
         count  <= count + 1'b1;
         if (step_done) begin
            active <= 1'b0;
         end
      end
   end

endmodule

// File: rtl/seq_alu.sv
// ---------------------------------------------------------------------------
// seq_alu
// Clocked ALU with a start/done handshake. Logic, shift, add and subtract
// (plus divide-by-zero and reserved codes) complete one cycle after accept;
// multiply and divide run WIDTH iterations in seq_muldiv.
// Ports:
//   clk, rst_n    clock and asynchronous active-low reset
//   start         request, sampled only while busy=0
//   op            operation code (alu_pkg::op_e)
//   a, b          operands, latched on accept
//   carry_in      ADD carry input
//   busy          iterative operation in progress
//   done          one-cycle pulse when the result outputs update
//   result        primary result (low product, quotient)
//   result_hi     high product or remainder, otherwise 0
//   carry_out     ADD carry, or SUB no-borrow, otherwise 0
//   valid         0 for divide-by-zero or reserved op
// ---------------------------------------------------------------------------
module seq_alu
   import alu_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [3:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             carry_in,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result,
   output logic [WIDTH-1:0] result_hi,
   output logic             carry_out,
   output logic             valid
);

   localparam int SHW = $clog2(WIDTH);

   state_e           state;
   state_e           next_state;
   logic             eng_load;
   logic             take_single;
   logic             take_iter;
   logic             step_done;
   logic [WIDTH-1:0] eng_hi;
   logic [WIDTH-1:0] eng_lo;

   logic [WIDTH-1:0] res_c;
   logic [WIDTH-1:0] hi_c;
   logic             cout_c;
   logic             valid_c;
   logic [WIDTH:0]   sub_diff;

   seq_muldiv #(.WIDTH(WIDTH)) u_muldiv (
      .clk       (clk),
      .rst_n     (rst_n),
      .load      (eng_load),
      .mode      (op == OP_DIV),
      .a         (a),
      .b         (b),
      .step_done (step_done),
      .hi        (eng_hi),
      .lo        (eng_lo)
   );

   assign busy = (state != IDLE);

   // Controller state register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   // Next state and capture strobes. Divide by zero never enters DIV: it is
   // answered directly by the single-cycle path.
   always_comb begin
      next_state  = state;
      eng_load    = 1'b0;
      take_single = 1'b0;
      take_iter   = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               if (op == OP_MUL) begin
                  next_state = MUL;
                  eng_load   = 1'b1;
               end else if (op == OP_DIV && b != '0) begin
                  next_state = DIV;
                  eng_load   = 1'b1;
               end else begin
                  take_single = 1'b1;
               end
            end
         end
         MUL, DIV: begin
            if (step_done) begin
               next_state = IDLE;
               take_iter  = 1'b1;
            end
         end
         default: next_state = IDLE;
      endcase
   end

   // Single-cycle datapath. The DIV entry is only ever captured with b=0.
   always_comb begin
      res_c    = '0;
      hi_c     = '0;
      cout_c   = 1'b0;
      valid_c  = 1'b1;
      sub_diff = {1'b0, a} - {1'b0, b};
      case (op)
         OP_AND:  res_c = a & b;
         OP_OR:   res_c = a | b;
         OP_XOR:  res_c = a ^ b;
         OP_XNOR: res_c = ~(a ^ b);
         OP_NAND: res_c = ~(a & b);
         OP_NOR:  res_c = ~(a | b);
         OP_NOT:  res_c = ~a;
         OP_SHL:  res_c = a << b[SHW-1:0];
         OP_SHR:  res_c = a >> b[SHW-1:0];
         OP_ADD:  {cout_c, res_c} = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, carry_in};
         OP_SUB: begin
            res_c  = sub_diff[WIDTH-1:0];
            cout_c = ~sub_diff[WIDTH];
         end
         OP_MUL:  res_c = '0;
         OP_DIV: begin
            res_c   = '1;
            hi_c    = a;
            valid_c = 1'b0;
         end
         default: valid_c = 1'b0;
      endcase
   end

   // Result registers: they only change on a completion and otherwise hold.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         done      <= 1'b0;
         result    <= '0;
         result_hi <= '0;
         carry_out <= 1'b0;
         valid     <= 1'b0;
      end else begin
         done <= take_single | take_iter;
         if (take_single) begin
            result    <= res_c;
            result_hi <= hi_c;
            carry_out <= cout_c;
            valid     <= valid_c;
         end else if (take_iter) begin
            result    <= eng_lo;
            result_hi <= eng_hi;
            carry_out <= 1'b0;
            valid     <= 1'b1;
         end
      end
   end

endmodule

// File: doc/seq_alu.md
# seq_alu

Parametrised, clocked successor to the combinational 4-bit ALU units (logic, shift, add, subtract, multiply, divide). All operations sit behind one start/done handshake at configurable width. Logic, shift, add and subtract finish in one cycle. Multiply (shift-add) and divide (restoring) run iteratively over WIDTH cycles. The block sits between a controller or sequencer and the register file.

## Interface
- WIDTH, 8, operand width; power of two, at least 4.
- SHW, $clog2(WIDTH), shift-amount width (derived; not overridden).
- clk  in  1  single clock; all state changes on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  request; sampled only while busy=0.
- op  in  4  operation code (see Operation).
- a, b  in  WIDTH  operands; latched when start is accepted.
- carry_in  in  1  ADD carry input; latched with the operands.
- busy  out  1  high while an iterative MUL/DIV is in progress.
- done  out  1  one-cycle pulse when result outputs update.
- result  out  WIDTH  primary result: low product, or quotient.
- result_hi  out  WIDTH  high product, or remainder; 0 for all other ops.
- carry_out  out  1  ADD carry, or SUB no-borrow (1 when a>=b); 0 otherwise.
- valid  out  1  0 for divide-by-zero or a reserved op; 1 otherwise.

## Operation
- Op codes:
  - 0 AND, 1 OR, 2 XOR, 3 XNOR, 4 NAND, 5 NOR.
  - 6 NOT a (b ignored).
  - 7 SHL and 8 SHR: logical, zero-fill, shift a by b[SHW-1:0].
  - 9 ADD: {carry_out,result} = a+b+carry_in.
  - 10 SUB: result = a-b mod 2^WIDTH.
  - 11 MUL: unsigned; {result_hi,result} = a*b.
  - 12 DIV: unsigned; result = a/b, result_hi = a%b.
  - 13-15 reserved.
- FSM states IDLE, MUL, DIV.
  - IDLE + start + op 11 -> MUL.
  - IDLE + start + op 12 with b!=0 -> DIV.
  - Every other accepted start stays in IDLE and completes immediately.
  - MUL/DIV -> IDLE when the iteration counter reaches WIDTH-1.
- Divide by zero: no iteration. result = all-ones, result_hi = a, valid=0.
- Reserved op: result, result_hi and carry_out = 0; valid=0.
- Outputs hold their last values until the next completion; done is 0 between completions.
- start while busy=1 is ignored; no queueing, and the latched operands are unaffected.
- Operand inputs may change freely after the accept edge.

## Timing
- Reset (async assert, synchronous-to-clk deassert by the system):
  - state=IDLE, counter=0.
  - busy=0, done=0, result=0, result_hi=0, carry_out=0, valid=0.
- Single-cycle ops: start sampled at edge k. Results and done=1 are registered at edge k, so they are visible in cycle k+1. Latency is 1; busy stays 0.
- Divide by zero and reserved ops: same latency 1 as the single-cycle ops.
- MUL/DIV: start sampled at edge k.
  - busy=1 from edge k through edge k+WIDTH-1.
  - Iterations 0..WIDTH-1 occur at edges k+1..k+WIDTH.
  - At edge k+WIDTH: results registered, done=1, busy=0. Latency is WIDTH+1.
- A new start may be sampled at the same edge that clears busy only if busy was already 0 in the cycle before. In other words, the first accept is possible in the done cycle. Back-to-back single-cycle ops may therefore produce done on consecutive cycles.
- Reset mid-operation aborts immediately: the iteration is discarded, all outputs return to reset values, and no done is produced.

## Structure
- Package alu_pkg holds:
  - op-code constants/enum (OP_AND..OP_DIV);
  - FSM state typedef;
  - default WIDTH constant.
- Sub-module seq_muldiv (WIDTH parameter) holds the iterative engine:
  - accumulator, partial remainder, counter;
  - ports: load, mode, a, b, step-done, hi/lo outputs.
- seq_alu holds the FSM, the combinational single-cycle datapath, and the output registers.

## Test plan
All scenarios use WIDTH=8.
- Reset: hold rst_n=0 and pulse clk -> all outputs 0. Assert rst_n=0 mid-MUL at iteration 3 -> busy=0 immediately, no done after release.
- Logic/shift: a=8'hCA, b=8'hA5.
  - AND -> 8'h80; XNOR -> 8'h90.
  - SHL with b=8'h03 -> 8'h50; SHR with b=8'h03 -> 8'h19.
  - Each gives done one cycle after start, busy never 1.
- Arithmetic:
  - ADD 8'hFF+8'h01, carry_in=1 -> result 8'h01, carry_out=1.
  - SUB 8'h05-8'h0A -> 8'hFB, carry_out=0.
- MUL 8'hD5*8'hAA -> result_hi=8'h8D, result=8'h72. busy high 8 cycles, done at cycle 9 after accept. A start issued in cycle 4 is ignored.
- DIV:
  - 8'd100/8'd7 -> result=14, result_hi=2, valid=1, latency 9.
  - 8'd37/0 -> result=8'hFF, result_hi=8'd37, valid=0, latency 1.
- Reserved op 14 -> result 0, valid=0. Back-to-back ADD,ADD,SUB accepts -> done high on three consecutive cycles with the correct results.
